// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key expander, the inverse key generation stage and the round datapath.
package aes_pkg;

  localparam int NR   = 10;
  localparam int RK_W = 128;

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} ks_state_t;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key load, status and round-key read bus of the AES-128 key expander.
interface aes_key_expander_if;
  import aes_pkg::*;

  logic [RK_W-1:0] key_in;
  logic            key_valid;
  logic            key_ready;
  logic            busy;
  logic            done;
  logic [RK_W-1:0] last_key;
  logic [3:0]      rk_idx;
  logic [RK_W-1:0] rk_out;

  modport master (
    output key_in, key_valid, rk_idx,
    input  key_ready, busy, done, last_key, rk_out
  );

  modport slave (
    input  key_in, key_valid, rk_idx,
    output key_ready, busy, done, last_key, rk_out
  );

endinterface

// File: rtl/aes_rk_store.sv
// Eleven-entry round-key register file: one write port, one registered read port that returns 0 beyond key 10.
module aes_rk_store
  import aes_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [RK_W-1:0] wdata,
  input  logic [3:0]      raddr,
  output logic [RK_W-1:0] rdata,
  output logic [RK_W-1:0] last_key
);

  logic [RK_W-1:0] mem [NR+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we && waddr <= 4'(NR)) mem[waddr] <= wdata;
      if (raddr <= 4'(NR)) rdata <= mem[raddr];
      else                 rdata <= '0;
    end
  end

  assign last_key = mem[NR];

endmodule

// File: rtl/sbox.sv
// Registered AES forward S-box: one byte lookup with one cycle of latency.
module sbox (
  input  logic       clk,
  input  logic [7:0] i_Seed_Data,
  output logic [7:0] ans
);

  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_ff @(posedge clk) begin
    ans <= TABLE[11'(2047) - {i_Seed_Data, 3'b000} -: 8];
  end

endmodule

// File: rtl/aes_key_expander.sv
// Forward AES-128 key schedule: one round every two clocks (S-box lookup, then word mixing) into a local key store.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  aes_key_expander_if.slave bus
);

  ks_state_t       state, state_nx;
  logic [3:0]      r;
  logic [RK_W-1:0] work;
  logic [31:0]     rot, sub_word, temp;
  logic [31:0]     w0n, w1n, w2n, w3n;
  logic            accept, we;
  logic [3:0]      waddr;
  logic [RK_W-1:0] wdata;

  assign rot = rot_word(work[31:0]);

  // The S-boxes sample every cycle; their output is only consumed in MIX, while the working key is stable.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .clk         (clk),
      .i_Seed_Data (rot[8*g +: 8]),
      .ans         (sub_word[8*g +: 8])
    );
  end

  assign temp = sub_word ^ {RCON[r], 24'h0};
  assign w0n  = work[127:96] ^ temp;
  assign w1n  = work[95:64]  ^ w0n;
  assign w2n  = work[63:32]  ^ w1n;
  assign w3n  = work[31:0]   ^ w2n;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    we            = 1'b0;
    waddr         = 4'd0;
    wdata         = {w0n, w1n, w2n, w3n};
    bus.key_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        bus.key_ready = 1'b1;
        bus.done      = (state == DONE);
        if (bus.key_valid) begin
          accept   = 1'b1;
          we       = 1'b1;
          wdata    = bus.key_in;
          state_nx = SUB;
        end
      end
      SUB: begin
        bus.busy = 1'b1;
        state_nx = MIX;
      end
      MIX: begin
        bus.busy = 1'b1;
        we       = 1'b1;
        waddr    = r + 4'd1;
        state_nx = (r == 4'(NR-1)) ? DONE : SUB;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r    <= '0;
      work <= '0;
    end else if (accept) begin
      r    <= '0;
      work <= bus.key_in;
    end else if (state == MIX) begin
      work <= {w0n, w1n, w2n, w3n};
      if (r != 4'(NR-1)) r <= r + 4'd1;
    end
  end

  aes_rk_store u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (bus.rk_idx),
    .rdata    (bus.rk_out),
    .last_key (bus.last_key)
  );

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using the FIPS-197 A.1 and C.1 key schedules as reference vectors.
module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cnt;

  aes_key_expander_if bus ();

  aes_key_expander dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_RK9 = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] A1_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a key for exactly one edge; afterwards the bench sits just past the accept edge.
  task automatic applyStimulus(input logic [127:0] key);
    bus.key_in    = key;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic readKey(input int idx, input string tag, input logic [127:0] exp);
    bus.rk_idx = 4'(idx);
    tick();
    checkOutput(tag, bus.rk_out, exp);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.key_in    = '0;
    bus.key_valid = 1'b0;
    bus.rk_idx    = '0;
    tick(3);
    checkOutput("rst_key_ready", 128'(bus.key_ready), 128'd1);
    checkOutput("rst_busy", 128'(bus.busy), 128'd0);
    checkOutput("rst_done", 128'(bus.done), 128'd0);
    checkOutput("rst_rk_out", bus.rk_out, '0);
    checkOutput("rst_last_key", bus.last_key, '0);

    // A key presented while reset is still low must not start a run.
    bus.key_in    = A1_KEY;
    bus.key_valid = 1'b1;
    tick();
    checkOutput("rst_valid_ignored", 128'(bus.busy), 128'd0);
    rst_n = 1'b1;
    applyStimulus(A1_KEY);
    checkOutput("a1_busy", 128'(bus.busy), 128'd1);
    checkOutput("a1_ready_low", 128'(bus.key_ready), 128'd0);
    waitDone(cnt);
    checkOutput("a1_latency", 128'(cnt), 128'd20);
    checkOutput("a1_busy_end", 128'(bus.busy), 128'd0);
    checkOutput("a1_ready_end", 128'(bus.key_ready), 128'd1);
    checkOutput("a1_last_key", bus.last_key, A1_RK[10]);

    for (int i = 0; i < 16; i++) begin
      if (i <= 10) readKey(i, $sformatf("a1_rk%0d", i), A1_RK[i]);
      else         readKey(i, $sformatf("a1_rk%0d", i), '0);
    end

    applyStimulus(C1_KEY);
    checkOutput("b2b_done_drop", 128'(bus.done), 128'd0);
    waitDone(cnt);
    checkOutput("c1_latency", 128'(cnt), 128'd20);
    checkOutput("c1_last_key", bus.last_key, C1_RK10);
    readKey(9, "c1_rk9", C1_RK9);
    readKey(0, "c1_rk0", C1_KEY);

    // Stray key_valid pulses during a run must be dropped.
    applyStimulus(A1_KEY);
    cnt = 0;
    while (!bus.done && cnt < 40) begin
      bus.key_in    = C1_KEY;
      bus.key_valid = (cnt == 4 || cnt == 11);
      if (bus.key_valid) checkOutput($sformatf("ign_ready_c%0d", cnt + 1), 128'(bus.key_ready), 128'd0);
      tick();
      cnt++;
    end
    bus.key_valid = 1'b0;
    checkOutput("ign_latency", 128'(cnt), 128'd20);
    checkOutput("ign_last_key", bus.last_key, A1_RK[10]);
    readKey(5, "ign_rk5", A1_RK[5]);

    applyStimulus(C1_KEY);
    tick(7);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_busy", 128'(bus.busy), 128'd0);
    checkOutput("mid_rst_done", 128'(bus.done), 128'd0);
    checkOutput("mid_rst_ready", 128'(bus.key_ready), 128'd1);
    checkOutput("mid_rst_rk_out", bus.rk_out, '0);
    checkOutput("mid_rst_last_key", bus.last_key, '0);
    rst_n = 1'b1;
    tick();
    applyStimulus(A1_KEY);
    waitDone(cnt);
    checkOutput("rerun_latency", 128'(cnt), 128'd20);
    checkOutput("rerun_last_key", bus.last_key, A1_RK[10]);
    readKey(1, "rerun_rk1", A1_RK[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
